// File: rtl/pcm_pkg.sv
// pcm_pkg: shared defaults and mode encodings
// for the PCM microphone sample FIFO.
package pcm_pkg;

  localparam int PCM_DBITS = 8;
  localparam int PCM_ABITS = 4;

  localparam int FWFT_REG = 0;
  localparam int FWFT_ON  = 1;

  localparam int EDGE_LEVEL = 0;
  localparam int EDGE_FALL  = 1;

  function automatic int pcm_depth(input int abits);
    return 1 << abits;
  endfunction

endpackage

// File: rtl/pcm_fifo_edge_strobe.sv
// edge_strobe: two-flop synchroniser with a
// one-cycle pulse on the input's 1->0 transition.
module edge_strobe (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_i,
  output logic strobe_o
);

  logic ff1_q;
  logic ff2_q;

  // synchroniser chain, cleared so reset drops in-flight strobes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      ff1_q <= in_i;
      ff2_q <= ff1_q;
    end
  end

  assign strobe_o = ~ff1_q & ff2_q;

endmodule

// File: rtl/pcm_fifo.sv
// pcm_fifo: sample FIFO between PCM capture and
// the consumer, with level/flags and sticky errors.
module pcm_fifo
  import pcm_pkg::*;
#(
  parameter int DBITS    = PCM_DBITS,
  parameter int ABITS    = PCM_ABITS,
  parameter int AF_LEVEL = pcm_depth(ABITS) - 2,
  parameter int AE_LEVEL = 1,
  parameter int FWFT     = FWFT_REG,
  parameter int EDGE     = EDGE_LEVEL
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr,
  input  logic             rd,
  input  logic [DBITS-1:0] din,
  input  logic             clr_err,
  output logic [DBITS-1:0] dout,
  output logic             dout_valid,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [ABITS:0]   level,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = pcm_depth(ABITS);

  localparam logic [ABITS:0] DEPTH_L = (ABITS+1)'(DEPTH);
  localparam logic [ABITS:0] AF_L    = (ABITS+1)'(AF_LEVEL);
  localparam logic [ABITS:0] AE_L    = (ABITS+1)'(AE_LEVEL);
  localparam logic [ABITS:0] ONE_L   = (ABITS+1)'(1);
  localparam logic [ABITS-1:0] PINC  = ABITS'(1);

  logic wr_s;
  logic rd_s;

  generate
    if (EDGE == EDGE_FALL) begin : g_edge
      edge_strobe u_wr (
        .clk_i    (clock),
        .rst_ni   (reset),
        .in_i     (wr),
        .strobe_o (wr_s)
      );
      edge_strobe u_rd (
        .clk_i    (clock),
        .rst_ni   (reset),
        .in_i     (rd),
        .strobe_o (rd_s)
      );
    end else begin : g_level
      assign wr_s = wr;
      assign rd_s = rd;
    end
  endgenerate

  logic [DBITS-1:0] mem_q [DEPTH];

  logic [ABITS-1:0] wr_ptr_q;
  logic [ABITS-1:0] wr_ptr_d;
  logic [ABITS-1:0] rd_ptr_q;
  logic [ABITS-1:0] rd_ptr_d;
  logic [ABITS:0]   level_q;
  logic [ABITS:0]   level_d;
  logic             full_q;
  logic             empty_q;
  logic             af_q;
  logic             ae_q;
  logic             ovf_q;
  logic             ovf_d;
  logic             unf_q;
  logic             unf_d;

  logic rd_ok;
  logic wr_ok;

  // a read frees a slot, so write-while-full is legal alongside it
  assign rd_ok = rd_s & ~empty_q;
  assign wr_ok = wr_s & (~full_q | rd_ok);

  // next pointers, occupancy and sticky error flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PINC;
    if (rd_ok) rd_ptr_d = rd_ptr_q + PINC;
    unique case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + ONE_L;
      2'b01:   level_d = level_q - ONE_L;
      default: level_d = level_q;
    endcase
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (wr_s & ~wr_ok) ovf_d = 1'b1;
    if (rd_s & ~rd_ok) unf_d = 1'b1;
  end

  // control state; flags come from next level, no rd/wr comb paths
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= (AF_L == '0);
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= (level_d == DEPTH_L);
      empty_q  <= (level_d == '0);
      af_q     <= (level_d >= AF_L);
      ae_q     <= (level_d <= AE_L);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // sample storage; left unreset
  always_ff @(posedge clock) begin
    if (wr_ok) mem_q[wr_ptr_q] <= din;
  end

  generate
    if (FWFT == FWFT_ON) begin : g_fwft
      assign dout       = empty_q ? '0 : mem_q[rd_ptr_q];
      assign dout_valid = ~empty_q;
    end else begin : g_reg
      logic [DBITS-1:0] dout_q;
      logic [DBITS-1:0] dout_d;
      logic             dv_q;
      logic             dv_d;

      // registered read: old word wins on a same-slot write
      always_comb begin
        dout_d = dout_q;
        dv_d   = 1'b0;
        if (rd_ok) begin
          dout_d = mem_q[rd_ptr_q];
          dv_d   = 1'b1;
        end
      end

      // read data register and its one-cycle valid pulse
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          dout_q <= '0;
          dv_q   <= 1'b0;
        end else begin
          dout_q <= dout_d;
          dv_q   <= dv_d;
        end
      end

      assign dout       = dout_q;
      assign dout_valid = dv_q;
    end
  endgenerate

  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign level        = level_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_pcm_fifo.sv
// tb_pcm_fifo: scoreboard bench over four FIFO
// configurations (registered, wide/random, FWFT, edge).
module tb_pcm_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic wr0 = 0, rd0 = 0, clr0 = 0;
  logic [7:0] din0 = 0, dout0;
  logic dv0, em0, fu0, ae0, af0, ov0, un0;
  logic [2:0] lv0;

  logic wr1 = 0, rd1 = 0, clr1 = 0;
  logic [7:0] din1 = 0, dout1;
  logic dv1, em1, fu1, ae1, af1, ov1, un1;
  logic [3:0] lv1;

  logic wr2 = 0, rd2 = 0, clr2 = 0;
  logic [7:0] din2 = 0, dout2;
  logic dv2, em2, fu2, ae2, af2, ov2, un2;
  logic [2:0] lv2;

  logic wr3 = 0, rd3 = 0, clr3 = 0;
  logic [7:0] din3 = 0, dout3;
  logic dv3, em3, fu3, ae3, af3, ov3, un3;
  logic [2:0] lv3;

  logic [7:0] sb0[$], sb1[$], sb2[$], sb3[$];

  pcm_fifo #(.DBITS(8), .ABITS(2), .AF_LEVEL(2), .AE_LEVEL(1),
             .FWFT(0), .EDGE(0)) u0 (
    .clock(clk), .reset(rst_n), .wr(wr0), .rd(rd0), .din(din0),
    .clr_err(clr0), .dout(dout0), .dout_valid(dv0), .empty(em0),
    .full(fu0), .almost_empty(ae0), .almost_full(af0), .level(lv0),
    .overflow(ov0), .underflow(un0));

  pcm_fifo #(.DBITS(8), .ABITS(3), .AE_LEVEL(1),
             .FWFT(0), .EDGE(0)) u1 (
    .clock(clk), .reset(rst_n), .wr(wr1), .rd(rd1), .din(din1),
    .clr_err(clr1), .dout(dout1), .dout_valid(dv1), .empty(em1),
    .full(fu1), .almost_empty(ae1), .almost_full(af1), .level(lv1),
    .overflow(ov1), .underflow(un1));

  pcm_fifo #(.DBITS(8), .ABITS(2), .AF_LEVEL(2), .AE_LEVEL(1),
             .FWFT(1), .EDGE(0)) u2 (
    .clock(clk), .reset(rst_n), .wr(wr2), .rd(rd2), .din(din2),
    .clr_err(clr2), .dout(dout2), .dout_valid(dv2), .empty(em2),
    .full(fu2), .almost_empty(ae2), .almost_full(af2), .level(lv2),
    .overflow(ov2), .underflow(un2));

  pcm_fifo #(.DBITS(8), .ABITS(2), .AF_LEVEL(2), .AE_LEVEL(1),
             .FWFT(0), .EDGE(1)) u3 (
    .clock(clk), .reset(rst_n), .wr(wr3), .rd(rd3), .din(din3),
    .clr_err(clr3), .dout(dout3), .dout_valid(dv3), .empty(em3),
    .full(fu3), .almost_empty(ae3), .almost_full(af3), .level(lv3),
    .overflow(ov3), .underflow(un3));

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pop_chk(input string nm, input logic [7:0] act,
                         inout logic [7:0] q[$]);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got output %0h want none", nm, act);
    end else begin
      chk(nm, act, q.pop_front());
    end
  endtask

  // monitor: compare every presented read word against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (dv0) pop_chk("u0_dout", dout0, sb0);
      if (dv1) pop_chk("u1_dout", dout1, sb1);
      if (dv2 && rd2) pop_chk("u2_dout", dout2, sb2);
      if (dv3) pop_chk("u3_dout", dout3, sb3);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] mq[$];
    logic mov, mun;
    logic w, r, rok, wok;
    logic [7:0] d;
    int pw;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_empty", em0, 1);
    chk("rst_full", fu0, 0);
    chk("rst_ae", ae0, 1);
    chk("rst_af", af0, 0);
    chk("rst_level", lv0, 0);
    chk("rst_dout", dout0, 0);
    chk("rst_dv", dv0, 0);
    chk("rst_ovf", ov0, 0);
    chk("rst_unf", un0, 0);
    chk("rst_fwft_dv", dv2, 0);
    chk("rst_edge_level", lv3, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // registered FIFO fill, overflow, same-edge rd/wr, drain
    wr0 = 1; din0 = 8'hA1; tick();
    chk("u0_w1_empty", em0, 0);
    chk("u0_w1_level", lv0, 1);
    chk("u0_w1_af", af0, 0);
    chk("u0_w1_ae", ae0, 1);
    din0 = 8'hA2; tick();
    chk("u0_w2_af", af0, 1);
    chk("u0_w2_ae", ae0, 0);
    din0 = 8'hA3; tick();
    din0 = 8'hA4; tick();
    chk("u0_full_level", lv0, 4);
    chk("u0_full", fu0, 1);
    chk("u0_full_af", af0, 1);
    din0 = 8'hEE; tick();
    chk("u0_ovf", ov0, 1);
    chk("u0_ovf_level", lv0, 4);
    wr0 = 0; clr0 = 1; tick();
    chk("u0_ovf_clr", ov0, 0);
    clr0 = 0;
    wr0 = 1; rd0 = 1; din0 = 8'hA5; sb0.push_back(8'hA1); tick();
    chk("u0_rw_level", lv0, 4);
    chk("u0_rw_full", fu0, 1);
    chk("u0_rw_ovf", ov0, 0);
    wr0 = 0;
    sb0.push_back(8'hA2); sb0.push_back(8'hA3);
    sb0.push_back(8'hA4); sb0.push_back(8'hA5);
    tick(4);
    chk("u0_drain_empty", em0, 1);
    chk("u0_drain_level", lv0, 0);
    chk("u0_drain_full", fu0, 0);
    tick();
    chk("u0_unf", un0, 1);
    chk("u0_unf_level", lv0, 0);
    chk("u0_unf_dout", dout0, 8'hA5);
    rd0 = 0; clr0 = 1; tick();
    chk("u0_unf_clr", un0, 0);
    clr0 = 0;
    rd0 = 1; wr0 = 1; din0 = 8'hB1; tick();
    chk("u0_rwe_level", lv0, 1);
    chk("u0_rwe_unf", un0, 1);
    chk("u0_rwe_empty", em0, 0);
    wr0 = 0; sb0.push_back(8'hB1); tick();
    chk("u0_last_empty", em0, 1);
    rd0 = 0; tick();

    // first-word-fall-through
    wr2 = 1; din2 = 8'h5A; tick();
    chk("u2_fall_dout", dout2, 8'h5A);
    chk("u2_fall_dv", dv2, 1);
    chk("u2_fall_empty", em2, 0);
    din2 = 8'h3C; tick();
    wr2 = 0;
    chk("u2_head_hold", dout2, 8'h5A);
    chk("u2_level2", lv2, 2);
    rd2 = 1; sb2.push_back(8'h5A); sb2.push_back(8'h3C); tick();
    chk("u2_pop_next", dout2, 8'h3C);
    chk("u2_pop_dv", dv2, 1);
    tick();
    rd2 = 0;
    chk("u2_pop_empty", em2, 1);
    chk("u2_pop_dv0", dv2, 0);
    tick();

    // falling-edge strobes
    din3 = 8'h77; wr3 = 1; tick(5);
    chk("u3_hold_level", lv3, 0);
    wr3 = 0; tick();
    chk("u3_fall1_level", lv3, 0);
    tick();
    chk("u3_fall2_level", lv3, 1);
    tick(3);
    chk("u3_once_level", lv3, 1);
    rd3 = 1; tick(5);
    chk("u3_rdhold_level", lv3, 1);
    rd3 = 0; sb3.push_back(8'h77); tick();
    chk("u3_rfall1_level", lv3, 1);
    tick();
    chk("u3_rfall2_level", lv3, 0);
    chk("u3_rfall2_dout", dout3, 8'h77);
    chk("u3_errs", {ov3, un3}, 0);
    tick();

    // randomised interleave against a reference queue, with reset
    mov = 0; mun = 0;
    for (int c = 0; c < 400; c++) begin
      pw = ((c / 24) % 2 == 0) ? 75 : 25;
      w = ($urandom_range(0, 99) < pw);
      r = ($urandom_range(0, 99) < (100 - pw));
      d = 8'($urandom);
      rok = r && (mq.size() > 0);
      wok = w && ((mq.size() < 8) || rok);
      if (rok) sb1.push_back(mq.pop_front());
      if (wok) mq.push_back(d);
      if (w && !wok) mov = 1;
      if (r && !rok) mun = 1;
      wr1 = w; rd1 = r; din1 = d;
      tick();
      chk("u1_level", lv1, mq.size());
      chk("u1_full", fu1, mq.size() == 8);
      chk("u1_empty", em1, mq.size() == 0);
      chk("u1_af", af1, mq.size() >= 6);
      chk("u1_ae", ae1, mq.size() <= 1);
      chk("u1_ovf", ov1, mov);
      chk("u1_unf", un1, mun);
      if (c == 250) begin
        wr1 = 1; rd1 = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("u1_mrst_level", lv1, 0);
        chk("u1_mrst_empty", em1, 1);
        chk("u1_mrst_full", fu1, 0);
        chk("u1_mrst_ae", ae1, 1);
        chk("u1_mrst_af", af1, 0);
        chk("u1_mrst_dv", dv1, 0);
        chk("u1_mrst_dout", dout1, 0);
        chk("u1_mrst_flags", {ov1, un1}, 0);
        mq.delete();
        sb1.delete();
        mov = 0; mun = 0;
        wr1 = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
    end
    wr1 = 0; rd1 = 0;
    tick(2);
    chk("sb_drained", sb0.size() + sb1.size() + sb2.size() + sb3.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pcm_fifo.md
# pcm_fifo

Parametrised synchronous FIFO for the PCM microphone audio path. It buffers DBITS-wide samples between the PDM/PCM capture logic and the consumer (UART, DAC or SoC bus). It generalises the earlier single-mode FIFO with:

- configurable depth, counting all 2^ABITS entries;
- level strobes or button-style falling-edge strobes;
- optional first-word-fall-through read;
- occupancy count, almost-full/almost-empty thresholds, and sticky overflow/underflow flags.

## Interface
Parameters:
- DBITS, 8: sample width.
- ABITS, 4: address bits; depth = 2^ABITS.
- AF_LEVEL, 2^ABITS-2: almost_full asserts when level >= AF_LEVEL.
- AE_LEVEL, 1: almost_empty asserts when level <= AE_LEVEL.
- FWFT, 0: 0 = registered read; 1 = head word presented on dout while not empty.
- EDGE, 0: 0 = rd/wr are one-cycle strobes; 1 = rd/wr are synchronised and act on their 1->0 transition.

Ports (one clock; reset is asynchronous and active-low):
- clock, in, 1: sole clock; all logic on rising edge.
- reset, in, 1: asynchronous, active-low reset.
- wr, in, 1: write request.
- rd, in, 1: read request.
- din, in, DBITS: write data, sampled on the accepted-write edge.
- clr_err, in, 1: synchronous clear of overflow/underflow.
- dout, out, DBITS: read data.
- dout_valid, out, 1: FWFT=0: one-cycle pulse with new dout. FWFT=1: equals ~empty.
- empty, out, 1: no stored words.
- full, out, 1: 2^ABITS stored words.
- almost_empty, out, 1: level <= AE_LEVEL.
- almost_full, out, 1: level >= AF_LEVEL.
- level, out, ABITS+1: stored word count, 0..2^ABITS.
- overflow, out, 1: sticky; a write was rejected.
- underflow, out, 1: sticky; a read was rejected.

## Operation
- Internal strobes wr_s and rd_s:
  - EDGE=0: wr_s = wr, rd_s = rd.
  - EDGE=1: each input passes two flops; the strobe is ~ff1 & ff2.
- Read accepted (rd_ok) = rd_s & ~empty.
- Write accepted (wr_ok) = wr_s & (~full | rd_ok). A write while full is legal when a read is accepted on the same edge.
- Pointers wr_ptr and rd_ptr are ABITS bits wide and wrap modulo 2^ABITS.
- Level update per edge: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.
- full = (level == 2^ABITS) and empty = (level == 0). Both are registered, derived from next-level.
- almost_full and almost_empty are registered, computed from next-level.
- Same-address read and write (full, rd and wr together): the read returns the old word (read-before-write).
- FWFT=0: on rd_ok, dout <= mem[rd_ptr] and dout_valid pulses for one cycle. Otherwise dout holds and dout_valid = 0.
- FWFT=1: dout = mem[rd_ptr] whenever ~empty. rd_ok pops the word and the next word appears the following cycle.
- Error flags:
  - overflow sets on wr_s & ~wr_ok.
  - underflow sets on rd_s & ~rd_ok.
  - clr_err clears both. A set event in the same cycle wins over clr_err.
- Memory contents are not reset.

## Timing
- Reset asserted: pointers = 0, level = 0, empty = 1, full = 0, almost_empty = 1, almost_full = (AF_LEVEL == 0), dout = 0, dout_valid = 0, overflow = 0, underflow = 0, sync flops = 0.
- Reset is asynchronous and may arrive mid-operation. The FIFO returns to the empty state immediately and any in-flight strobe is discarded.
- EDGE=1: wr sampled 1 at edge n and 0 at edge n+1 gives the write at edge n+2. din must be stable at edge n+2. rd behaves the same way.
- Write-to-read latency:
  - A word written at edge n gives empty = 0 after edge n.
  - FWFT=1: the word is on dout after edge n.
  - FWFT=0: the earliest rd_ok is edge n+1, with dout valid after it.
- Flags and level update on the same edge as the accepted operation; there are no combinational paths from rd/wr to the flags.

## Structure
- Shared package pcm_pkg holds:
  - default DBITS/ABITS for the audio path;
  - a function for depth = 2^ABITS;
  - constants for FWFT/EDGE mode encodings.
- Sub-module edge_strobe (2-flop synchroniser plus falling-edge detector), instantiated for rd and wr when EDGE=1.

## Test plan
- ABITS=2, FWFT=0: write A1,A2,A3,A4. Expect level 4, full = 1, almost_full = 1 (AF=2). Read 4 times: dout A1..A4, each with a dout_valid pulse, then empty = 1.
- Full FIFO: a 5th write sets overflow = 1 and stored data is unchanged. rd and wr on the same edge: dout = oldest word, level stays 4, full stays 1, no overflow.
- Empty FIFO: rd gives underflow = 1, dout and level unchanged. clr_err clears it on the next edge. Simultaneous rd and wr on empty: only the write is accepted, level = 1, underflow = 1.
- FWFT=1: write 0x5A at edge n; dout = 0x5A and dout_valid = 1 after edge n. Pop: dout shows the next word, or empty = 1.
- EDGE=1: hold wr high 5 cycles then drop it. Exactly one write happens, 2 edges after the fall. A held-high rd produces no reads until it is released.
- 10 wrap-around cycles at ABITS=3 with random interleaved rd/wr against a reference queue: data order, level and flags match every cycle. Asserting reset mid-burst returns all outputs to their reset values immediately.
